// File: rtl/blackjack_game_ctrl.sv
// BlackJack game sequencer: deals paced cards from the free-running counter,
// keeps player/dealer totals with soft-ace handling and reports the result.
module blackjack_game_ctrl #(
  parameter int WIDTH        = 12,
  parameter int DEALER_STAND = 17
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Hit,
  input  logic             i_Stay,
  input  logic [WIDTH-1:0] i_Count,
  input  logic             i_TwoSec,
  output logic             o_RstCounter,
  output logic             o_ActCounter,
  output logic [3:0]       o_Card,
  output logic [4:0]       o_PlayerSum,
  output logic [4:0]       o_DealerSum,
  output logic             o_Busy,
  output logic             o_Win,
  output logic             o_Lose,
  output logic             o_Tie,
  output logic [3:0]       o_State
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_DRAW   = 4'd1;
  localparam logic [3:0] S_PACE   = 4'd2;
  localparam logic [3:0] S_PLAYER = 4'd3;
  localparam logic [3:0] S_DEALER = 4'd4;
  localparam logic [3:0] S_RESULT = 4'd5;

  localparam logic [4:0] STAND = 5'(DEALER_STAND);
  localparam logic [4:0] BJ    = 5'd21;

  logic [3:0] state;
  logic [1:0] deal_idx;
  logic       dealing;
  logic       to_dealer;
  logic [4:0] player_sum;
  logic [4:0] dealer_sum;
  logic       player_soft;
  logic       dealer_soft;
  logic [3:0] card;
  logic       win;
  logic       lose;
  logic       tie;

  logic [3:0] rank;
  logic [3:0] value;
  logic [4:0] cur_sum;
  logic       cur_soft;
  logic [4:0] new_sum;
  logic       new_soft;
  logic       res_win;
  logic       res_lose;
  logic       res_tie;

  // Only the low nibble is used as the card rank.
  logic unused_count;
  assign unused_count = &{1'b0, i_Count};

  // Ace counts 11 while it fits; an over-21 soft hand demotes one ace.
  // Worst case before demotion is soft 21 + 10 = 31, so 5 bits suffice.
  always_comb begin
    rank     = i_Count[3:0];
    value    = (rank == 4'd0 || rank >= 4'd10) ? 4'd10 : rank;
    cur_sum  = to_dealer ? dealer_sum : player_sum;
    cur_soft = to_dealer ? dealer_soft : player_soft;
    new_sum  = cur_sum + 5'(value);
    new_soft = cur_soft;
    if (value == 4'd1 && cur_sum <= 5'd10) begin
      new_sum  = cur_sum + 5'd11;
      new_soft = 1'b1;
    end
    if (new_sum > BJ && new_soft) begin
      new_sum  = new_sum - 5'd10;
      new_soft = 1'b0;
    end
  end

  always_comb begin
    res_win  = 1'b0;
    res_lose = 1'b0;
    res_tie  = 1'b0;
    if (player_sum > BJ)
      res_lose = 1'b1;
    else if (dealer_sum > BJ || player_sum > dealer_sum)
      res_win = 1'b1;
    else if (player_sum == dealer_sum)
      res_tie = 1'b1;
    else
      res_lose = 1'b1;
  end

  always_ff @(posedge clk_50M or negedge i_Reset) begin
    if (!i_Reset) begin
      state       <= S_IDLE;
      deal_idx    <= 2'd0;
      dealing     <= 1'b0;
      to_dealer   <= 1'b0;
      player_sum  <= 5'd0;
      dealer_sum  <= 5'd0;
      player_soft <= 1'b0;
      dealer_soft <= 1'b0;
      card        <= 4'd0;
      win         <= 1'b0;
      lose        <= 1'b0;
      tie         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_RESULT: begin
          if (i_Start) begin
            player_sum  <= 5'd0;
            dealer_sum  <= 5'd0;
            player_soft <= 1'b0;
            dealer_soft <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            tie         <= 1'b0;
            deal_idx    <= 2'd0;
            dealing     <= 1'b1;
            to_dealer   <= 1'b0;
            state       <= S_DRAW;
          end
        end
        S_DRAW: begin
          card <= value;
          if (to_dealer) begin
            dealer_sum  <= new_sum;
            dealer_soft <= new_soft;
          end else begin
            player_sum  <= new_sum;
            player_soft <= new_soft;
          end
          state <= S_PACE;
        end
        S_PACE: begin
          if (i_TwoSec) begin
            if (dealing) begin
              if (deal_idx == 2'd3) begin
                dealing <= 1'b0;
                state   <= (player_sum == BJ) ? S_DEALER : S_PLAYER;
              end else begin
                deal_idx  <= deal_idx + 2'd1;
                to_dealer <= ~to_dealer;
                state     <= S_DRAW;
              end
            end else if (!to_dealer) begin
              if (player_sum > BJ) begin
                win   <= res_win;
                lose  <= res_lose;
                tie   <= res_tie;
                state <= S_RESULT;
              end else begin
                state <= S_PLAYER;
              end
            end else begin
              state <= S_DEALER;
            end
          end
        end
        S_PLAYER: begin
          if (i_Stay) begin
            state <= S_DEALER;
          end else if (i_Hit) begin
            to_dealer <= 1'b0;
            state     <= S_DRAW;
          end
        end
        S_DEALER: begin
          if (dealer_sum < STAND) begin
            to_dealer <= 1'b1;
            state     <= S_DRAW;
          end else begin
            win   <= res_win;
            lose  <= res_lose;
            tie   <= res_tie;
            state <= S_RESULT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear and activate are decoded from disjoint states, never both high.
  assign o_RstCounter = (state == S_DRAW);
  assign o_ActCounter = (state == S_PACE);
  assign o_Busy       = (state == S_PACE);
  assign o_Card       = card;
  assign o_PlayerSum  = player_sum;
  assign o_DealerSum  = dealer_sum;
  assign o_Win        = win;
  assign o_Lose       = lose;
  assign o_Tie        = tie;
  assign o_State      = state;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Scoreboard bench for blackjack_game_ctrl: a card server plays the Counter,
// a hand-level model predicts totals and results, monitors compare.
`timescale 1ns/1ps
module tb_blackjack_game_ctrl;

  localparam int WIDTH = 12;
  localparam int ST_IDLE   = 0;
  localparam int ST_PACE   = 2;
  localparam int ST_PLAYER = 3;
  localparam int ST_DEALER = 4;
  localparam int ST_RESULT = 5;

  logic             clk_50M = 1'b0;
  logic             i_Reset;
  logic             i_Start;
  logic             i_Hit;
  logic             i_Stay;
  logic [WIDTH-1:0] i_Count;
  logic             i_TwoSec;
  logic             o_RstCounter;
  logic             o_ActCounter;
  logic [3:0]       o_Card;
  logic [4:0]       o_PlayerSum;
  logic [4:0]       o_DealerSum;
  logic             o_Busy;
  logic             o_Win;
  logic             o_Lose;
  logic             o_Tie;
  logic [3:0]       o_State;

  blackjack_game_ctrl #(.WIDTH(WIDTH), .DEALER_STAND(17)) dut (
    .clk_50M      (clk_50M),
    .i_Reset      (i_Reset),
    .i_Start      (i_Start),
    .i_Hit        (i_Hit),
    .i_Stay       (i_Stay),
    .i_Count      (i_Count),
    .i_TwoSec     (i_TwoSec),
    .o_RstCounter (o_RstCounter),
    .o_ActCounter (o_ActCounter),
    .o_Card       (o_Card),
    .o_PlayerSum  (o_PlayerSum),
    .o_DealerSum  (o_DealerSum),
    .o_Busy       (o_Busy),
    .o_Win        (o_Win),
    .o_Lose       (o_Lose),
    .o_Tie        (o_Tie),
    .o_State      (o_State)
  );

  always #10 clk_50M = ~clk_50M;

  typedef struct {
    int card;
    int ps;
    int ds;
  } card_exp_t;

  card_exp_t card_q[$];
  int        res_q[$];
  int        deck[$];
  byte       acts[$];
  int        p_cards[$];
  int        d_cards[$];
  int        deal_n;
  int        phase;
  bit        res_pushed;
  bit        quiet;
  int        checks = 0;
  int        errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int cval(input int r);
    return (r == 0 || r >= 10) ? 10 : r;
  endfunction

  // Best blackjack total: aces as 1, one of them as 11 if it fits.
  function automatic int total(input int c[$]);
    int t;
    bit ace;
    t = 0;
    ace = 0;
    foreach (c[i]) begin
      t += c[i];
      if (c[i] == 1) ace = 1;
    end
    if (ace && t + 10 <= 21) t += 10;
    return t;
  endfunction

  // Result code: 4 = win, 2 = lose, 1 = tie.
  function automatic int judge(input int p, input int d);
    if (p > 21) return 2;
    if (d > 21 || p > d) return 4;
    if (p == d) return 1;
    return 2;
  endfunction

  // phase: 0 initial deal, 1 player turn, 2 dealer turn, 3 hand over
  task automatic model_end();
    int pt, dt;
    pt = total(p_cards);
    dt = total(d_cards);
    if (phase == 2 && dt >= 17) phase = 3;
    if (phase == 3 && !res_pushed) begin
      res_q.push_back(judge(pt, dt));
      res_pushed = 1;
    end
  endtask

  task automatic model_card(input int r);
    int v;
    card_exp_t e;
    v = cval(r);
    chk("draw_allowed", int'(phase != 3), 1);
    if (phase == 3) return;
    case (phase)
      0: begin
        if (deal_n % 2 == 0) p_cards.push_back(v);
        else d_cards.push_back(v);
        deal_n++;
        if (deal_n == 4) phase = (total(p_cards) == 21) ? 2 : 1;
      end
      1: begin
        p_cards.push_back(v);
        if (total(p_cards) > 21) phase = 3;
      end
      default: d_cards.push_back(v);
    endcase
    e.card = v;
    e.ps = total(p_cards);
    e.ds = total(d_cards);
    card_q.push_back(e);
    model_end();
  endtask

  task automatic model_reset();
    p_cards.delete();
    d_cards.delete();
    deal_n = 0;
    phase = 0;
    res_pushed = 0;
  endtask

  // Counter stand-in: supplies a rank on each clear pulse, then paces.
  initial begin : card_server
    int r, n;
    logic [WIDTH-1:0] c;
    @(negedge clk_50M);
    forever begin
      if (o_RstCounter === 1'b1) begin
        chk("rst_act_excl", int'(o_ActCounter), 0);
        r = (deck.size() > 0) ? deck.pop_front() : int'($urandom_range(0, 15));
        c = WIDTH'($urandom);
        c[3:0] = 4'(r);
        i_Count = c;
        model_card(r);
        @(negedge clk_50M);
        n = $urandom_range(0, 3);
        repeat (n) begin
          if (!quiet && $urandom_range(0, 1) == 0) begin
            i_Hit = 1'b1;
            i_Stay = 1'($urandom_range(0, 1));
            i_Start = 1'($urandom_range(0, 1));
            @(negedge clk_50M);
            i_Hit = 1'b0;
            i_Stay = 1'b0;
            i_Start = 1'b0;
            if (!quiet) chk("pace_ignore", int'(o_State), ST_PACE);
          end else begin
            @(negedge clk_50M);
          end
        end
        i_TwoSec = 1'b1;
        @(negedge clk_50M);
        i_TwoSec = 1'b0;
      end else begin
        @(negedge clk_50M);
      end
    end
  end

  // Monitor: card totals on PACE entry, flags on RESULT entry.
  initial begin : monitor
    bit prev_act;
    int prev_state;
    card_exp_t e;
    int er;
    prev_act = 0;
    prev_state = ST_IDLE;
    forever begin
      @(negedge clk_50M);
      if (i_Reset && o_ActCounter && !prev_act) begin
        if (card_q.size() == 0) begin
          chk("card_q_underflow", card_q.size(), 1);
        end else begin
          e = card_q.pop_front();
          chk("card", int'(o_Card), e.card);
          chk("player_sum", int'(o_PlayerSum), e.ps);
          chk("dealer_sum", int'(o_DealerSum), e.ds);
          chk("busy_pace", int'(o_Busy), 1);
          chk("rst_one_cycle", int'(o_RstCounter), 0);
        end
      end
      if (i_Reset && o_State == ST_RESULT && prev_state != ST_RESULT) begin
        if (res_q.size() == 0) begin
          chk("res_q_underflow", res_q.size(), 1);
        end else begin
          er = res_q.pop_front();
          chk("result_flags", int'({o_Win, o_Lose, o_Tie}), er);
          chk("result_act", int'(o_ActCounter), 0);
        end
      end
      prev_act = o_ActCounter;
      prev_state = int'(o_State);
    end
  end

  task automatic pulse(input bit h, input bit s, input bit st, input bit ts);
    i_Hit = h;
    i_Stay = s;
    i_Start = st;
    i_TwoSec = ts;
    @(negedge clk_50M);
    i_Hit = 1'b0;
    i_Stay = 1'b0;
    i_Start = 1'b0;
    i_TwoSec = 1'b0;
  endtask

  task automatic settle(output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (o_State == ST_PLAYER || o_State == ST_RESULT) begin
        ok = 1;
        break;
      end
      @(negedge clk_50M);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: state %0d, required PLAYER or RESULT within 400 cycles", o_State);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, int'(o_State), ST_IDLE);
    chk({tag, "_rst"}, int'(o_RstCounter), 0);
    chk({tag, "_act"}, int'(o_ActCounter), 0);
    chk({tag, "_busy"}, int'(o_Busy), 0);
    chk({tag, "_card"}, int'(o_Card), 0);
    chk({tag, "_psum"}, int'(o_PlayerSum), 0);
    chk({tag, "_dsum"}, int'(o_DealerSum), 0);
    chk({tag, "_flags"}, int'({o_Win, o_Lose, o_Tie}), 0);
  endtask

  task automatic play_hand(input int thr);
    bit ok;
    int pt;
    byte a;
    model_reset();
    pulse(0, 0, 1, 0);
    for (int step = 0; step < 12; step++) begin
      settle(ok);
      if (!ok) break;
      chk("settled_state", int'(o_State), (phase == 1) ? ST_PLAYER : ST_RESULT);
      if (o_State != ST_PLAYER) break;
      if ($urandom_range(0, 2) == 0) begin
        pulse(0, 0, 1, 1);
        chk("player_ignore", int'(o_State), ST_PLAYER);
      end
      pt = total(p_cards);
      if (acts.size() > 0) a = acts.pop_front();
      else a = (pt < thr) ? "H" : "S";
      if (a == "H") begin
        pulse(1, 0, 0, 0);
      end else begin
        phase = 2;
        model_end();
        pulse(a == "B", 1, 0, 0);
        chk("stay_state", int'(o_State), ST_DEALER);
      end
    end
    repeat (3) @(negedge clk_50M);
    chk("result_hold_state", int'(o_State), ST_RESULT);
    chk("result_hold_flags", int'({o_Win, o_Lose, o_Tie}),
        judge(total(p_cards), total(d_cards)));
  endtask

  task automatic reset_mid_pace();
    bit seen;
    quiet = 1;
    deck = '{7, 9, 12, 5};
    model_reset();
    pulse(0, 0, 1, 0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (o_ActCounter) begin
        seen = 1;
        break;
      end
      @(negedge clk_50M);
    end
    chk("pace_reached", int'(seen), 1);
    #2 i_Reset = 1'b0;
    #1 check_zero("async_rst");
    repeat (6) @(negedge clk_50M);
    i_Reset = 1'b1;
    deck.delete();
    phase = 3;
    res_pushed = 1;
    repeat (2) @(negedge clk_50M);
    check_zero("post_rst");
    quiet = 0;
  endtask

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: run did not complete within 60000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    i_Reset = 1'b0;
    i_Start = 1'b0;
    i_Hit = 1'b0;
    i_Stay = 1'b0;
    i_TwoSec = 1'b0;
    i_Count = '0;
    quiet = 0;
    phase = 3;
    res_pushed = 1;
    repeat (3) @(negedge clk_50M);
    check_zero("reset");
    i_Reset = 1'b1;
    @(negedge clk_50M);

    reset_mid_pace();

    deck = '{7, 9, 12, 5, 8};
    acts = '{"H"};
    play_hand(17);

    deck = '{1, 5, 1, 6, 13};
    acts = '{"H", "S"};
    play_hand(17);

    deck = '{10, 10, 9, 6, 15};
    acts = '{"S"};
    play_hand(17);

    deck = '{10, 10, 9, 7};
    acts = '{"S"};
    play_hand(17);

    deck = '{10, 10, 8, 7};
    acts = '{"B"};
    play_hand(17);

    deck = '{10, 10, 8, 8};
    acts = '{"S"};
    play_hand(17);

    deck = '{1, 10, 10, 9};
    play_hand(17);

    deck = '{10, 1, 9, 6};
    acts = '{"S"};
    play_hand(17);

    for (int h = 0; h < 25; h++) play_hand(int'($urandom_range(12, 19)));

    repeat (5) @(negedge clk_50M);
    chk("card_q_empty", card_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
